// File: rtl/g_rd_ctrl_if.sv
// rtl/g_rd_ctrl_if.sv - control, g memory read port and output stream bundle for g_rd_ctrl
interface g_rd_ctrl_if #(
  parameter int G_ADDR_W = 8,
  parameter int G_DAT_W  = 64
);
  logic                start;
  logic                busy;
  logic                done;
  logic                parity_ok;
  logic [G_ADDR_W-1:0] g_addr;
  logic                g_re;
  logic [G_DAT_W-1:0]  g_din;
  logic                out_valid;
  logic                out_ready;
  logic [G_DAT_W-1:0]  out_dat;
  logic                out_last;

  modport master (
    input  start, g_din, out_ready,
    output busy, done, parity_ok, g_addr, g_re, out_valid, out_dat, out_last
  );

  modport slave (
    output start, g_din, out_ready,
    input  busy, done, parity_ok, g_addr, g_re, out_valid, out_dat, out_last
  );
endinterface

// File: rtl/g_rd_ctrl.sv
// rtl/g_rd_ctrl.sv - streams the g polynomial from memory through a 2-entry buffer with parity check
// Optional G_RD_MASK_EN: zero the unused high bits of the final word on out_dat.
module g_rd_ctrl #(
  parameter int G_ADDR_W  = 8,
  parameter int G_DAT_W   = 64,
  parameter int LAST_ADDR = 172,
  parameter int LAST_BITS = 51
) (
  input  logic        clk,
  input  logic        rst,
  g_rd_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [G_ADDR_W-1:0] LAST_A     = G_ADDR_W'(LAST_ADDR);
  localparam logic [G_DAT_W-1:0]  VALID_MASK = {G_DAT_W{1'b1}} >> (G_DAT_W - LAST_BITS);

  state_t              state, state_nxt;
  logic [G_ADDR_W-1:0] cnt;
  logic                pend, pend_last;
  logic [G_DAT_W-1:0]  fifo_dat  [2];
  logic                fifo_last [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          fifo_cnt;
  logic                acc, par_q;

  logic                fifo_ne, pop, fpop, push, issue, start_acc;
  logic [1:0]          occ;
  logic [G_DAT_W-1:0]  head_dat, out_word, ret_word;
  logic                head_last, acc_nxt;

  // A word returning this cycle is visible immediately when the buffer is empty.
  assign fifo_ne   = (fifo_cnt != 2'd0);
  assign head_dat  = fifo_ne ? fifo_dat[rd_ptr]  : bus.g_din;
  assign head_last = fifo_ne ? fifo_last[rd_ptr] : pend_last;
  assign occ       = fifo_cnt + {1'b0, pend};
  assign pop       = bus.out_valid && bus.out_ready;
  assign fpop      = pop && fifo_ne;
  assign push      = pend && !(!fifo_ne && pop);
  assign issue     = (state == READ) && ((occ - {1'b0, pop}) <= 2'd1);
  assign start_acc = (state == IDLE) && bus.start;

  assign ret_word  = pend_last ? (bus.g_din & VALID_MASK) : bus.g_din;
  assign acc_nxt   = acc ^ (pend & (^ret_word));

`ifdef G_RD_MASK_EN
  assign out_word = head_last ? (head_dat & VALID_MASK) : head_dat;
`else
  assign out_word = head_dat;
`endif

  assign bus.out_valid = fifo_ne || pend;
  assign bus.out_dat   = bus.out_valid ? out_word : '0;
  assign bus.out_last  = bus.out_valid && head_last;
  assign bus.g_re      = issue;
  assign bus.g_addr    = cnt;
  assign bus.parity_ok = par_q;

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = READ;
      READ: begin
        bus.busy = 1'b1;
        if (issue && (cnt == LAST_A)) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (pop && head_last) state_nxt = FIN;
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      acc       <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= issue;
      pend_last <= issue && (cnt == LAST_A);
      if (start_acc) begin
        cnt   <= '0;
        acc   <= 1'b0;
        par_q <= 1'b0;
      end else begin
        if (issue && (cnt != LAST_A)) cnt <= cnt + 1'b1;
        acc <= acc_nxt;
        if ((state == DRAIN) && (state_nxt == FIN)) par_q <= acc_nxt;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (fpop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fpop};
    end
  end

  // Buffer storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr]  <= bus.g_din;
      fifo_last[wr_ptr] <= pend_last;
    end
  end
endmodule

// File: tb/tb_g_rd_ctrl.sv
// tb/tb_g_rd_ctrl.sv - table-driven self-checking bench for g_rd_ctrl
module tb_g_rd_ctrl;
  localparam int AW = 8, DW = 64, LA = 172, LB = 51;
`ifdef G_RD_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  typedef struct {
    int          pat;
    int          ready_pct;
    int          rst_at;
    bit          dbl_start;
    bit          timing;
    bit          exp_par;
    logic [63:0] exp_last;
  } scn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  g_rd_ctrl_if #(.G_ADDR_W(AW), .G_DAT_W(DW)) bus ();

  g_rd_ctrl #(.G_ADDR_W(AW), .G_DAT_W(DW), .LAST_ADDR(LA), .LAST_BITS(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] gmem [0:255];
  always @(posedge clk) if (bus.g_re) bus.g_din <= gmem[bus.g_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got_q [$];
  bit            got_last [$];
  int  done_cnt, start_cyc, first_hs, last_hs, stab_err, max_out, issued, accepted;
  bit  par_at_done, busy_at_done, prev_stall, prev_last;
  logic [DW-1:0] prev_dat;
  int  errors = 0, checks = 0;

  always @(negedge clk) begin
    if (rst) begin
      issued = 0; accepted = 0; prev_stall = 1'b0;
    end else begin
      if (bus.start && start_cyc < 0) start_cyc = cyc;
      if (prev_stall && (!bus.out_valid || bus.out_dat !== prev_dat || bus.out_last !== prev_last))
        stab_err++;
      if (bus.g_re) issued++;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_dat);
        got_last.push_back(bus.out_last);
        accepted++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (bus.done) begin
        done_cnt++;
        par_at_done  = bus.parity_ok;
        busy_at_done = bus.busy;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_dat   = bus.out_dat;
      prev_last  = bus.out_last;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 256; i++) gmem[i] = '0;
    case (pat)
      0: for (int i = 0; i <= LA; i++) gmem[i] = 64'(i);
      1: gmem[LA] = '1;
      2: gmem[5] = 64'h3;
      default: begin gmem[0] = 64'h1; gmem[LA] = 64'h1 << 51; end
    endcase
  endtask

  function automatic logic [63:0] exp_word(input int i);
    logic [63:0] w;
    w = gmem[i];
    if (MASKED && i == LA) w = w & 64'h0007_FFFF_FFFF_FFFF;
    return w;
  endfunction

  task automatic clear_mon();
    got_q.delete(); got_last.delete();
    done_cnt = 0; start_cyc = -1; first_hs = -1; last_hs = -1;
    stab_err = 0; max_out = 0; issued = 0; accepted = 0; prev_stall = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_stream(input int id, input bit exp_par, input logic [63:0] exp_last,
                              input bit timing);
    int bad_dat, bad_last;
    bad_dat = 0; bad_last = 0;
    chk($sformatf("s%0d_word_count", id), 64'(got_q.size()), 64'(LA + 1));
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== exp_word(i)) bad_dat++;
      if (got_last[i] !== (i == LA)) bad_last++;
    end
    chk($sformatf("s%0d_data_errs", id), 64'(bad_dat), 64'(0));
    chk($sformatf("s%0d_last_errs", id), 64'(bad_last), 64'(0));
    if (got_q.size() > LA) chk($sformatf("s%0d_last_word", id), got_q[LA], exp_last);
    chk($sformatf("s%0d_done_cnt", id), 64'(done_cnt), 64'(1));
    chk($sformatf("s%0d_parity", id), 64'(par_at_done), 64'(exp_par));
    chk($sformatf("s%0d_busy_at_done", id), 64'(busy_at_done), 64'(0));
    chk($sformatf("s%0d_stall_unstable", id), 64'(stab_err), 64'(0));
    chk($sformatf("s%0d_outstanding_le2", id), 64'(max_out <= 2), 64'(1));
    if (timing) begin
      chk($sformatf("s%0d_first_lat", id), 64'(first_hs - start_cyc), 64'(2));
      chk($sformatf("s%0d_last_lat", id), 64'(last_hs - start_cyc), 64'(LA + 2));
    end
    @(negedge clk);
    chk($sformatf("s%0d_parity_held", id), 64'(bus.parity_ok), 64'(exp_par));
  endtask

  task automatic run_scn(input int id, input scn_t s);
    int  n;
    bit  did_rst;
    fill(s.pat);
    clear_mon();
    bus.out_ready = ($urandom_range(99) < s.ready_pct);
    pulse_start();
    n = 0; did_rst = 1'b0;
    while (done_cnt == 0 && n < 6000) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < s.ready_pct);
      bus.start     = s.dbl_start && (n == 30);
      if (s.rst_at >= 0 && !did_rst && got_q.size() >= s.rst_at) begin
        rst = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; did_rst = 1'b1;
        chk($sformatf("s%0d_rst_valid", id), 64'(bus.out_valid), 64'(0));
        chk($sformatf("s%0d_rst_busy", id), 64'(bus.busy), 64'(0));
        got_q.delete(); got_last.delete();
        start_cyc = -1; first_hs = -1;
        repeat (3) @(posedge clk);
        chk($sformatf("s%0d_no_stale", id), 64'(got_q.size()), 64'(0));
        #1;
        pulse_start();
      end
      n++;
    end
    chk($sformatf("s%0d_timeout", id), 64'(n < 6000), 64'(1));
    repeat (4) @(posedge clk);
    check_stream(id, s.exp_par, s.exp_last, s.timing);
    @(posedge clk); #1;
  endtask

  scn_t scns [7];

  initial begin
    scns[0] = '{pat: 0, ready_pct: 100, rst_at: -1, dbl_start: 0, timing: 1, exp_par: 0,
                exp_last: 64'd172};
    scns[1] = '{pat: 1, ready_pct: 100, rst_at: -1, dbl_start: 0, timing: 1, exp_par: 1,
                exp_last: MASKED ? 64'h0007_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF};
    scns[2] = '{pat: 2, ready_pct: 100, rst_at: -1, dbl_start: 0, timing: 0, exp_par: 0,
                exp_last: 64'd0};
    scns[3] = '{pat: 0, ready_pct: 30, rst_at: -1, dbl_start: 0, timing: 0, exp_par: 0,
                exp_last: 64'd172};
    scns[4] = '{pat: 3, ready_pct: 50, rst_at: -1, dbl_start: 0, timing: 0, exp_par: 1,
                exp_last: MASKED ? 64'd0 : 64'h0008_0000_0000_0000};
    scns[5] = '{pat: 0, ready_pct: 100, rst_at: 80, dbl_start: 0, timing: 0, exp_par: 0,
                exp_last: 64'd172};
    scns[6] = '{pat: 0, ready_pct: 100, rst_at: -1, dbl_start: 1, timing: 1, exp_par: 0,
                exp_last: 64'd172};

    fill(0);
    clear_mon();
    rst = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_parity", 64'(bus.parity_ok), 64'(0));
    chk("rst_g_re", 64'(bus.g_re), 64'(0));
    chk("rst_g_addr", 64'(bus.g_addr), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_out_dat", bus.out_dat, 64'(0));
    repeat (3) @(negedge clk);
    chk("rst_over_start_idle", 64'(bus.busy), 64'(0));
    chk("idle_ready_no_words", 64'(got_q.size()), 64'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_scn(i, scns[i]);

    fill(3);
    clear_mon();
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_issued", 64'(issued), 64'(2));
    chk("stall_valid", 64'(bus.out_valid), 64'(1));
    chk("stall_dat", bus.out_dat, 64'h1);
    chk("stall_busy", 64'(bus.busy), 64'(1));
    chk("stall_parity_cleared", 64'(bus.parity_ok), 64'(0));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 1000 && done_cnt == 0; n++) @(posedge clk);
    chk("stall_done_seen", 64'(done_cnt), 64'(1));
    repeat (3) @(posedge clk);
    check_stream(7, 1'b1, MASKED ? 64'd0 : 64'h0008_0000_0000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/g_rd_ctrl.md
G_RD_CTRL -- requirements
Module: g_rd_ctrl

Interface
REQ-001 Parameter G_ADDR_W, default 8, g memory address width.
REQ-002 Parameter G_DAT_W, default 64, g memory and output word width.
REQ-003 Parameter LAST_ADDR, default 172, address of the final g word.
REQ-004 Parameter LAST_BITS, default 51, number of valid LSBs in the final word (1..G_DAT_W).
REQ-005 clk  input  1  sole clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle request to stream the g polynomial out.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse after the final word handshake.
REQ-010 parity_ok  output  1  high when the g Hamming weight over valid bits is odd.
REQ-011 g_addr  output  G_ADDR_W  g memory read address.
REQ-012 g_re  output  1  g memory read enable; data returns on g_din exactly one cycle later.
REQ-013 g_din  input  G_DAT_W  g memory read data.
REQ-014 out_valid  output  1  out_dat holds a valid word.
REQ-015 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-016 out_dat  output  G_DAT_W  streamed g word, address order 0..LAST_ADDR.
REQ-017 out_last  output  1  high with the word from LAST_ADDR.

Function
REQ-018 FSM states: IDLE, READ, DRAIN, FIN; start is sampled only in IDLE and ignored otherwise.
REQ-019 IDLE + start -> READ; read address counter and parity accumulator cleared; parity_ok cleared.
REQ-020 READ: g_re asserted with g_addr = counter when the 2-entry output buffer has room for the in-flight read plus the new one; counter increments on each issued read.
REQ-021 READ -> DRAIN in the cycle the read of LAST_ADDR issues; no read beyond LAST_ADDR is ever issued.
REQ-022 Returned data enters the output buffer in FIFO order; no word lost or duplicated under any out_ready pattern.
REQ-023 out_valid, out_dat and out_last hold stable while out_valid is high and out_ready is low.
REQ-024 Minimum latency: first out_valid two cycles after start; with out_ready held high, one word per cycle thereafter (LAST_ADDR+1 words in LAST_ADDR+1 consecutive cycles).
REQ-025 Parity: each returned word XOR-reduced into the accumulator; for LAST_ADDR only bits [LAST_BITS-1:0] included.
REQ-026 DRAIN -> FIN on the handshake of the out_last word; FIN -> IDLE unconditionally next cycle, with done high for that single FIN cycle.
REQ-027 parity_ok = accumulator value, valid from the done cycle and held until the next accepted start.
REQ-028 g_re low and g_addr held in IDLE, DRAIN and FIN.
REQ-029 out_ready high with out_valid low has no effect; out_ready low indefinitely stalls with no state change beyond the filled buffer.

Reset
REQ-030 On rst: state IDLE; busy, done, parity_ok, g_re, out_valid, out_last = 0; g_addr, out_dat, counter, accumulator = 0.
REQ-031 rst mid-stream aborts immediately: buffer emptied, data returning from a read issued before reset discarded, no done pulse.
REQ-032 rst has priority over start in the same cycle.

Configuration
REQ-033 Macro G_RD_MASK_EN defined: bits [G_DAT_W-1:LAST_BITS] of the out_last word forced to 0 on out_dat.
REQ-034 G_RD_MASK_EN undefined: out_last word passed unmodified; parity computation identical in both builds.

Verification
REQ-035 Memory word k = k, out_ready = 1, start pulse -> words 0..172 on 173 consecutive cycles, first two cycles after start, out_last only on 172, done one cycle after.
REQ-036 Word 172 = 0xFFFF_FFFF_FFFF_FFFF, all others 0 -> parity_ok = 1 (51 ones); with G_RD_MASK_EN out_dat = 0x0007_FFFF_FFFF_FFFF, without it all ones.
REQ-037 All words 0 except word 5 = 0x3 -> parity_ok = 0.
REQ-038 out_ready random 30% duty -> 173 words in order, out_dat stable during every stall, never more than 2 reads outstanding beyond accepted words.
REQ-039 rst at word 80 then new start -> stream restarts at word 0, no stale word, exactly one done.
REQ-040 start pulsed again during READ -> ignored; exactly 173 words and one done.
